// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one memory port between the I-cache and D-cache line-fill ports.
// A grant is held for a whole line transaction and released only by mem_resp.
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;
    // Memory always sees a line-aligned address, whatever offset bits the cache supplies.
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   i_pending, d_pending;

    assign i_pending = i_read | i_write;
    assign d_pending = d_read | d_write;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_addr     = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_wdata    = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the side that did not win last time goes next.
                if (i_pending && d_pending) begin
                    if (last_grant_q == GRANT_I) begin
                        state_d      = SERVE_D;
                        last_grant_d = GRANT_D;
                    end else begin
                        state_d      = SERVE_I;
                        last_grant_d = GRANT_I;
                    end
                end else if (i_pending) begin
                    state_d      = SERVE_I;
                    last_grant_d = GRANT_I;
                end else if (d_pending) begin
                    state_d      = SERVE_D;
                    last_grant_d = GRANT_D;
                end
            end

            SERVE_I: begin
                mem_addr  = i_addr & LINE_MASK;
                mem_read  = i_read;
                mem_write = i_write;
                mem_wdata = i_wdata;
                if (mem_resp) begin
                    i_resp  = 1'b1;
                    state_d = IDLE;
                end
            end

            SERVE_D: begin
                mem_addr  = d_addr & LINE_MASK;
                mem_read  = d_read;
                mem_write = d_write;
                mem_wdata = d_wdata;
                if (mem_resp) begin
                    d_resp  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a cycle-by-cycle vector table followed by a
// hand-driven sustained-contention sequence with a small responsive memory.
module tb_cache_arbiter;

    localparam logic [255:0] Z  = '0;
    localparam logic [255:0] IW = {8{32'h5A5A_0001}};
    localparam logic [255:0] AA = {8{32'hAAAA_AAAA}};
    localparam logic [255:0] L1 = {8{32'h1111_2222}};
    localparam logic [255:0] L2 = {8{32'h3333_4444}};
    localparam logic [255:0] L3 = {8{32'h5555_6666}};

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_addr, d_addr, mem_addr;
    logic         i_read, i_write, d_read, d_write;
    logic [255:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic         i_resp, d_resp, mem_read, mem_write, mem_resp;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic         chk;
        logic         rst;
        logic [31:0]  iAddr;
        logic         iRead;
        logic         iWrite;
        logic [31:0]  dAddr;
        logic         dRead;
        logic         dWrite;
        logic [255:0] dWdata;
        logic [255:0] memRdata;
        logic         memResp;
        logic         expIResp;
        logic         expDResp;
        logic         expMemRead;
        logic         expMemWrite;
        logic [31:0]  expMemAddr;
        logic [255:0] expMemWdata;
    } vec_t;

    vec_t vecs[$];

    cache_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_write(i_write), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic addVec(input logic chk, input logic r,
                          input logic [31:0] ia, input logic ir, input logic iw,
                          input logic [31:0] da, input logic dr, input logic dw,
                          input logic [255:0] dwd, input logic [255:0] mrd, input logic mresp,
                          input logic eI, input logic eD, input logic eRd, input logic eWr,
                          input logic [31:0] eA, input logic [255:0] eWd);
        vec_t v;
        v.chk = chk; v.rst = r;
        v.iAddr = ia; v.iRead = ir; v.iWrite = iw;
        v.dAddr = da; v.dRead = dr; v.dWrite = dw; v.dWdata = dwd;
        v.memRdata = mrd; v.memResp = mresp;
        v.expIResp = eI; v.expDResp = eD; v.expMemRead = eRd; v.expMemWrite = eWr;
        v.expMemAddr = eA; v.expMemWdata = eWd;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst       = v.rst;
        i_addr    = v.iAddr;
        i_read    = v.iRead;
        i_write   = v.iWrite;
        i_wdata   = IW;
        d_addr    = v.dAddr;
        d_read    = v.dRead;
        d_write   = v.dWrite;
        d_wdata   = v.dWdata;
        mem_rdata = v.memRdata;
        mem_resp  = v.memResp;
    endtask

    task automatic checkOutput(input string name, input int step,
                               input logic [255:0] actual, input logic [255:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, step, actual, expected);
        end
    endtask

    initial begin
        vec_t v;
        int   idleCycles;
        logic expectD;

        rst = 1'b1; i_addr = '0; i_read = 0; i_write = 0; i_wdata = IW;
        d_addr = '0; d_read = 0; d_write = 0; d_wdata = '0;
        mem_rdata = '0; mem_resp = 0;

        // Reset, then I read alone
        addVec(0,1, 32'h0,0,0,    32'h0,0,0,   Z, Z,0,  0,0,0,0, 32'h0,   Z);
        addVec(1,0, 32'h0,0,0,    32'h0,0,0,   Z, Z,0,  0,0,0,0, 32'h0,   Z);
        addVec(1,0, 32'h40,1,0,   32'h0,0,0,   Z, Z,0,  0,0,0,0, 32'h0,   Z);
        addVec(1,0, 32'h40,1,0,   32'h0,0,0,   Z, L1,0, 0,0,1,0, 32'h40,  IW);
        addVec(1,0, 32'h40,1,0,   32'h0,0,0,   Z, L1,1, 1,0,1,0, 32'h40,  IW);
        addVec(1,0, 32'h40,0,0,   32'h0,0,0,   Z, Z,0,  0,0,0,0, 32'h0,   Z);
        // D writeback alone
        addVec(1,0, 32'h0,0,0,    32'h800,0,1, AA, Z,0,  0,0,0,0, 32'h0,   Z);
        addVec(1,0, 32'h0,0,0,    32'h800,0,1, AA, Z,0,  0,0,0,1, 32'h800, AA);
        addVec(1,0, 32'h0,0,0,    32'h800,0,1, AA, L2,1, 0,1,0,1, 32'h800, AA);
        addVec(1,0, 32'h0,0,0,    32'h800,0,0, Z,  Z,0,  0,0,0,0, 32'h0,   Z);
        // Tie after reset: D first (line-aligned), one IDLE gap, then I
        addVec(1,1, 32'h0,0,0,    32'h0,0,0,   Z, Z,0,  0,0,0,0, 32'h0,   Z);
        addVec(1,0, 32'h0,1,0,    32'h20C,1,0, Z, Z,0,  0,0,0,0, 32'h0,   Z);
        addVec(1,0, 32'h0,1,0,    32'h20C,1,0, Z, Z,0,  0,0,1,0, 32'h200, Z);
        addVec(1,0, 32'h0,1,0,    32'h20C,1,0, Z, L2,1, 0,1,1,0, 32'h200, Z);
        addVec(1,0, 32'h0,1,0,    32'h20C,0,0, Z, Z,0,  0,0,0,0, 32'h0,   Z);
        addVec(1,0, 32'h0,1,0,    32'h0,0,0,   Z, Z,0,  0,0,1,0, 32'h0,   IW);
        addVec(1,0, 32'h0,1,0,    32'h0,0,0,   Z, L3,1, 1,0,1,0, 32'h0,   IW);
        addVec(1,0, 32'h0,0,0,    32'h0,0,0,   Z, Z,0,  0,0,0,0, 32'h0,   Z);
        // Spurious mem_resp in IDLE
        addVec(1,0, 32'h0,0,0,    32'h0,0,0,   Z, L1,1, 0,0,0,0, 32'h0,   Z);
        addVec(1,0, 32'h1000,1,0, 32'h0,0,0,   Z, L1,1, 0,0,0,0, 32'h0,   Z);
        addVec(1,0, 32'h1000,1,0, 32'h0,0,0,   Z, Z,0,  0,0,1,0, 32'h1000,IW);
        addVec(1,0, 32'h1000,1,0, 32'h0,0,0,   Z, L1,1, 1,0,1,0, 32'h1000,IW);
        addVec(1,0, 32'h0,0,0,    32'h0,0,0,   Z, Z,0,  0,0,0,0, 32'h0,   Z);
        // Reset mid-transaction in SERVE_D, then a tie must go to D again
        addVec(1,0, 32'h0,0,0,    32'h3C0,1,0, Z, Z,0,  0,0,0,0, 32'h0,   Z);
        addVec(1,1, 32'h0,0,0,    32'h3C0,1,0, Z, Z,0,  0,0,1,0, 32'h3C0, Z);
        addVec(1,0, 32'h40,1,0,   32'h3C0,1,0, Z, Z,0,  0,0,0,0, 32'h0,   Z);
        addVec(1,0, 32'h40,1,0,   32'h3C0,1,0, Z, Z,0,  0,0,1,0, 32'h3C0, Z);
        addVec(1,0, 32'h40,1,0,   32'h3C0,1,0, Z, L2,1, 0,1,1,0, 32'h3C0, Z);
        addVec(1,0, 32'h0,0,0,    32'h0,0,0,   Z, Z,0,  0,0,0,0, 32'h0,   Z);

        foreach (vecs[k]) begin
            v = vecs[k];
            @(posedge clk); #1;
            applyStimulus(v);
            @(negedge clk);
            if (v.chk) begin
                checkOutput("i_resp",    k, i_resp,    v.expIResp);
                checkOutput("d_resp",    k, d_resp,    v.expDResp);
                checkOutput("mem_read",  k, mem_read,  v.expMemRead);
                checkOutput("mem_write", k, mem_write, v.expMemWrite);
                checkOutput("mem_addr",  k, mem_addr,  v.expMemAddr);
                checkOutput("mem_wdata", k, mem_wdata, v.expMemWdata);
                checkOutput("i_rdata",   k, i_rdata,   v.memRdata);
                checkOutput("d_rdata",   k, d_rdata,   v.memRdata);
            end
        end

        // Sustained contention: both sides keep requesting; grants must go D, I, D, I
        @(posedge clk); #1;
        rst = 1'b1; i_read = 0; d_read = 0; i_write = 0; d_write = 0; mem_resp = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        i_addr = 32'h100; i_read = 1'b1;
        d_addr = 32'h2E0; d_read = 1'b1; d_wdata = Z;
        for (int t = 0; t < 4; t++) begin
            expectD = (t % 2 == 0);
            idleCycles = 0;
            @(negedge clk);
            while (!mem_read && idleCycles < 10) begin
                idleCycles++;
                @(negedge clk);
            end
            checkOutput("contention mem_read", t, mem_read, 1'b1);
            if (!mem_read) break;
            checkOutput("contention idle gap", t, idleCycles, 1);
            checkOutput("contention grant addr", t, mem_addr, expectD ? 32'h2E0 : 32'h100);
            checkOutput("contention early resp", t, {i_resp, d_resp}, 2'b00);
            @(posedge clk); #1;
            mem_resp = 1'b1; mem_rdata = L3;
            @(negedge clk);
            checkOutput("contention i_resp", t, i_resp, !expectD);
            checkOutput("contention d_resp", t, d_resp, expectD);
            @(posedge clk); #1;
            mem_resp = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
